// File: rtl/hsv_pkg.sv
// Purpose: shared types, widths and constants for the RGB565-to-HSV converter.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package hsv_pkg;

  localparam int DIV_W = 13;  // dividend/quotient width, covers 63*100 = 6300
  localparam int CH_W  = 6;   // scaled channel width
  localparam int H_W   = 9;   // hue output width
  localparam int P_W   = 7;   // saturation/value output width

  localparam logic [DIV_W-1:0] K60  = 13'd60;
  localparam logic [DIV_W-1:0] K100 = 13'd100;
  localparam logic [CH_W-1:0]  K63  = 6'd63;
  localparam logic [DIV_W-1:0] K120 = 13'd120;
  localparam logic [DIV_W-1:0] K240 = 13'd240;
  localparam logic [DIV_W-1:0] K360 = 13'd360;

  typedef enum logic [2:0] {
    IDLE, PREP, DIV_V, DIV_S, DIV_H, FIN, DONE
  } state_t;

  // Which channel holds the maximum; ties resolve R, then G, then B.
  typedef enum logic [1:0] {
    SEL_R, SEL_G, SEL_B
  } sel_t;

  // Percentage quotients never exceed 100; the clamp only narrows the width.
  function automatic logic [P_W-1:0] sat_pct(input logic [DIV_W-1:0] q);
    return (q > K100) ? P_W'(100) : q[P_W-1:0];
  endfunction

  // Hue sector offset and sign. neg means the difference term was negative.
  // Near-red pixels with a tiny negative difference yield 360 - 0 = 360.
  function automatic logic [H_W-1:0] hue_deg(input sel_t sel, input logic neg,
                                             input logic [DIV_W-1:0] q);
    logic [DIV_W-1:0] base;
    logic [DIV_W-1:0] h;
    case (sel)
      SEL_G:   base = K120;
      SEL_B:   base = K240;
      default: base = neg ? K360 : '0;
    endcase
    h = neg ? (base - q) : (base + q);
    return (h > K360) ? H_W'(360) : h[H_W-1:0];
  endfunction

endpackage

// File: rtl/hsv_seq_divider.sv
// Purpose: restoring unsigned divider, 13-bit dividend by 6-bit divisor, one quotient bit per cycle.
// Latency: start cycle loads, 13 iteration edges follow; done_o flags the cycle of the last iteration edge.
// Backpressure: none; start_i restarts unconditionally, quotient holds until the next start.
// Ports: clk/reset, start_i, dividend_i, divisor_i, done_o, quotient_o.
module hsv_seq_divider
  import hsv_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [DIV_W-1:0] dividend_i,
  input  logic [CH_W-1:0]  divisor_i,
  output logic             done_o,
  output logic [DIV_W-1:0] quotient_o
);

  // acc holds the dividend shifting out of the top and the quotient shifting in at the bottom.
  logic [DIV_W-1:0] acc_q, acc_d;
  logic [CH_W-1:0]  rem_q, rem_d;
  logic [CH_W-1:0]  dsr_q, dsr_d;
  logic [3:0]       iter_q, iter_d;
  logic             zero_q, zero_d;
  logic [CH_W:0]    trial;

  always_comb begin
    acc_d  = acc_q;
    rem_d  = rem_q;
    dsr_d  = dsr_q;
    iter_d = iter_q;
    zero_d = zero_q;
    trial  = {rem_q, acc_q[DIV_W-1]};
    if (start_i) begin
      acc_d  = dividend_i;
      rem_d  = '0;
      zero_d = (divisor_i == '0);
      // Divide by 1 instead of 0 so the schedule is unchanged; result is masked below.
      dsr_d  = zero_d ? CH_W'(1) : divisor_i;
      iter_d = 4'(DIV_W);
    end else if (iter_q != '0) begin
      iter_d = iter_q - 4'd1;
      if (trial >= {1'b0, dsr_q}) begin
        rem_d = CH_W'(trial - {1'b0, dsr_q});
        acc_d = {acc_q[DIV_W-2:0], 1'b1};
      end else begin
        rem_d = trial[CH_W-1:0];
        acc_d = {acc_q[DIV_W-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q  <= '0;
      rem_q  <= '0;
      dsr_q  <= '0;
      iter_q <= '0;
      zero_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      rem_q  <= rem_d;
      dsr_q  <= dsr_d;
      iter_q <= iter_d;
      zero_q <= zero_d;
    end
  end

  assign done_o     = (iter_q == 4'd1) && !start_i;
  assign quotient_o = zero_q ? '0 : acc_q;

endmodule

// File: rtl/hsv_convert_ctrl.sv
// Purpose: RGB565-to-HSV converter sequencing one shared divider through V, S and H quotients.
// Latency: accept at edge E0, out_valid high after E44; one pixel in flight, 46-cycle throughput.
// Backpressure: in_ready only in IDLE; result held stable in DONE until out_ready.
// Ports: clk/reset, in_valid/in_ready/in_rgb, out_valid/out_ready, h_out/s_out/v_out, busy.
module hsv_convert_ctrl
  import hsv_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [15:0]    in_rgb,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [H_W-1:0] h_out,
  output logic [P_W-1:0] s_out,
  output logic [P_W-1:0] v_out,
  output logic           busy
);

  state_t state_q, state_d;
  logic   ld_q, ld_d;  // first cycle of a DIV_* state: load the divider

  logic [CH_W-1:0]  r6_q, g6_q, b6_q, max_q, delta_q;
  logic [CH_W-1:0]  r6_d, g6_d, b6_d, max_d, delta_d, min_c;
  sel_t             sel_q, sel_d;
  logic [DIV_W-1:0] dvd_v_q, dvd_s_q, dvd_h_q, dvd_v_d, dvd_s_d, dvd_h_d;
  logic             neg_q, neg_d;
  logic [P_W-1:0]   v_q, s_q, v_d, s_d, v_out_q, s_out_q, v_out_d, s_out_d;
  logic [H_W-1:0]   h_out_q, h_out_d;
  logic [CH_W-1:0]  diff_c;

  logic             div_done;
  logic [DIV_W-1:0] div_dvd, div_quot;
  logic [CH_W-1:0]  div_dsr;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = PREP;
      PREP:    state_d = DIV_V;
      DIV_V:   if (div_done) state_d = DIV_S;
      DIV_S:   if (div_done) state_d = DIV_H;
      DIV_H:   if (div_done) state_d = FIN;
      FIN:     state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ld_d = (state_d != state_q) &&
           ((state_d == DIV_V) || (state_d == DIV_S) || (state_d == DIV_H));
  end

  always_comb begin
    r6_d = r6_q;  g6_d = g6_q;  b6_d = b6_q;
    max_d = max_q;  delta_d = delta_q;  sel_d = sel_q;
    dvd_v_d = dvd_v_q;  dvd_s_d = dvd_s_q;  dvd_h_d = dvd_h_q;  neg_d = neg_q;
    v_d = v_q;  s_d = s_q;
    h_out_d = h_out_q;  s_out_d = s_out_q;  v_out_d = v_out_q;
    min_c = '0;
    diff_c = '0;
    case (state_q)
      IDLE: begin
        r6_d = {in_rgb[15:11], 1'b0};
        g6_d = in_rgb[10:5];
        b6_d = {in_rgb[4:0], 1'b0};
        if (r6_d >= g6_d && r6_d >= b6_d) begin
          sel_d = SEL_R;  max_d = r6_d;
        end else if (g6_d >= b6_d) begin
          sel_d = SEL_G;  max_d = g6_d;
        end else begin
          sel_d = SEL_B;  max_d = b6_d;
        end
        min_c = (r6_d <= g6_d) ? r6_d : g6_d;
        if (b6_d < min_c) min_c = b6_d;
        delta_d = max_d - min_c;
      end
      PREP: begin
        case (sel_q)
          SEL_G: begin neg_d = b6_q < r6_q; diff_c = neg_d ? r6_q - b6_q : b6_q - r6_q; end
          SEL_B: begin neg_d = r6_q < g6_q; diff_c = neg_d ? g6_q - r6_q : r6_q - g6_q; end
          default: begin neg_d = g6_q < b6_q; diff_c = neg_d ? b6_q - g6_q : g6_q - b6_q; end
        endcase
        dvd_v_d = DIV_W'(max_q) * K100;
        dvd_s_d = DIV_W'(delta_q) * K100;
        dvd_h_d = DIV_W'(diff_c) * K60;
      end
      // The previous quotient is still in the divider during the load cycle.
      DIV_S: if (ld_q) v_d = sat_pct(div_quot);
      DIV_H: if (ld_q) s_d = sat_pct(div_quot);
      FIN: begin
        h_out_d = (delta_q == '0) ? '0 : hue_deg(sel_q, neg_q, div_quot);
        s_out_d = s_q;
        v_out_d = v_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    div_dvd = dvd_v_q;
    div_dsr = K63;
    case (state_q)
      DIV_S:   begin div_dvd = dvd_s_q; div_dsr = max_q;   end
      DIV_H:   begin div_dvd = dvd_h_q; div_dsr = delta_q; end
      default: ;
    endcase
  end

  hsv_seq_divider u_div (
    .clk        (clk),
    .reset      (reset),
    .start_i    (ld_q),
    .dividend_i (div_dvd),
    .divisor_i  (div_dsr),
    .done_o     (div_done),
    .quotient_o (div_quot)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;  ld_q <= 1'b0;
      r6_q <= '0;  g6_q <= '0;  b6_q <= '0;
      max_q <= '0;  delta_q <= '0;  sel_q <= SEL_R;
      dvd_v_q <= '0;  dvd_s_q <= '0;  dvd_h_q <= '0;  neg_q <= 1'b0;
      v_q <= '0;  s_q <= '0;
      h_out_q <= '0;  s_out_q <= '0;  v_out_q <= '0;
    end else begin
      state_q <= state_d;  ld_q <= ld_d;
      r6_q <= r6_d;  g6_q <= g6_d;  b6_q <= b6_d;
      max_q <= max_d;  delta_q <= delta_d;  sel_q <= sel_d;
      dvd_v_q <= dvd_v_d;  dvd_s_q <= dvd_s_d;  dvd_h_q <= dvd_h_d;  neg_q <= neg_d;
      v_q <= v_d;  s_q <= s_d;
      h_out_q <= h_out_d;  s_out_q <= s_out_d;  v_out_q <= v_out_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign h_out     = h_out_q;
  assign s_out     = s_out_q;
  assign v_out     = v_out_q;

endmodule

// File: tb/tb_hsv_convert_ctrl.sv
// Purpose: self-checking bench for hsv_convert_ctrl (directed table, corner sequences, random vs model).
// Latency: checks 44-edge result latency and 46-cycle throughput.
// Backpressure: exercises out_ready held low in DONE with a second pixel pending.
module tb_hsv_convert_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] in_rgb = '0;
  logic        in_ready, out_valid, busy;
  logic [8:0]  h_out;
  logic [6:0]  s_out, v_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  hsv_convert_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_rgb    (in_rgb),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .h_out     (h_out),
    .s_out     (s_out),
    .v_out     (v_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] rgb;
    int          h;
    int          s;
    int          v;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", nm, got, exp);
    end
  endtask

  // Reference: HSV straight from the arithmetic definition on scaled channels.
  function automatic void model(input logic [15:0] p, output int h, output int s, output int v);
    int r, g, b, mx, mn, d, diff, q;
    r = int'(p[15:11]) * 2;
    g = int'(p[10:5]);
    b = int'(p[4:0]) * 2;
    mx = r; if (g > mx) mx = g; if (b > mx) mx = b;
    mn = r; if (g < mn) mn = g; if (b < mn) mn = b;
    d = mx - mn;
    v = mx * 100 / 63;
    s = (mx == 0) ? 0 : d * 100 / mx;
    if (d == 0) h = 0;
    else if (r == mx) begin
      diff = g - b; q = 60 * (diff < 0 ? -diff : diff) / d;
      h = (diff >= 0) ? q : 360 - q;
    end else if (g == mx) begin
      diff = b - r; q = 60 * (diff < 0 ? -diff : diff) / d;
      h = (diff >= 0) ? 120 + q : 120 - q;
    end else begin
      diff = r - g; q = 60 * (diff < 0 ? -diff : diff) / d;
      h = (diff >= 0) ? 240 + q : 240 - q;
    end
  endfunction

  // Called at #1 after a rising edge. Returns the cycle count of the accepting edge.
  task automatic send(input logic [15:0] rgb, output int acc);
    int n;
    n = 0;
    in_rgb = rgb;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("accept_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1;
    acc = cyc;
    in_valid = 1'b0;
  endtask

  // Counts rising edges until out_valid is seen.
  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 300) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  vec_t tbl[8];
  int   acc, acc2, lat, eh, es, ev;
  logic [8:0] h0;
  logic [6:0] s0, v0;
  logic bad;

  initial begin
    tbl[0] = '{16'hF800,   0, 100,  98};
    tbl[1] = '{16'hFFFF, 120,   1, 100};
    tbl[2] = '{16'h0000,   0,   0,   0};
    tbl[3] = '{16'h001F, 240, 100,  98};
    tbl[4] = '{16'hF81F, 300, 100,  98};
    tbl[5] = '{16'h07E0, 120, 100, 100};
    tbl[6] = '{16'h8410,   0,   0,  50};
    tbl[7] = '{16'hFC00,  30, 100,  98};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hsv", {h_out, s_out, v_out}, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Directed table.
    foreach (tbl[i]) begin
      send(tbl[i].rgb, acc);
      chk("busy_after_accept", 32'(busy), 32'd1);
      wait_out(lat);
      chk("tbl_latency", 32'(lat), 32'd44);
      chk("tbl_h", 32'(h_out), 32'(tbl[i].h));
      chk("tbl_s", 32'(s_out), 32'(tbl[i].s));
      chk("tbl_v", 32'(v_out), 32'(tbl[i].v));
      take();
      chk("tbl_out_valid_drop", 32'(out_valid), 32'd0);
      chk("tbl_hold_h", 32'(h_out), 32'(tbl[i].h));
    end

    // Output stall with a second pixel waiting.
    send(16'hFC00, acc);
    wait_out(lat);
    chk("stall_first_latency", 32'(lat), 32'd44);
    h0 = h_out; s0 = s_out; v0 = v_out;
    in_rgb = 16'h07E0;
    in_valid = 1'b1;
    bad = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (h_out !== h0 || s_out !== s0 || v_out !== v0 || out_valid !== 1'b1 || in_ready !== 1'b0)
        bad = 1'b1;
    end
    chk("stall_stable", 32'(bad), 32'd0);
    chk("stall_h_value", 32'(h0), 32'd30);
    take();
    chk("stall_ready_after_hs", 32'(in_ready), 32'd1);
    send(16'h07E0, acc);
    wait_out(lat);
    chk("stall_second_latency", 32'(lat), 32'd44);
    chk("stall_second_hsv", {h_out, s_out, v_out}, {9'd120, 7'd100, 7'd100});
    take();

    // Throughput with out_ready held high.
    out_ready = 1'b1;
    send(16'hF81F, acc);
    in_rgb = 16'h001F;
    in_valid = 1'b1;
    wait_out(lat);
    chk("tput_first_h", 32'(h_out), 32'd300);
    send(16'h001F, acc2);
    chk("tput_interval", 32'(acc2 - acc), 32'd46);
    wait_out(lat);
    chk("tput_second_h", 32'(h_out), 32'd240);
    @(posedge clk);
    #1;
    out_ready = 1'b0;

    // Reset pulsed in the middle of the S division.
    send(16'hF800, acc);
    repeat (20) @(posedge clk);
    #1;
    chk("mid_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_hsv", {h_out, s_out, v_out}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    bad = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    chk("mid_rst_no_output", 32'(bad), 32'd0);
    chk("mid_rst_hsv_after", {h_out, s_out, v_out}, 32'd0);
    send(16'hF800, acc);
    wait_out(lat);
    chk("post_rst_latency", 32'(lat), 32'd44);
    chk("post_rst_hsv", {h_out, s_out, v_out}, {9'd0, 7'd100, 7'd98});
    take();

    // Random pixels against the reference model.
    for (int i = 0; i < 24; i++) begin
      logic [15:0] p;
      p = 16'($urandom);
      model(p, eh, es, ev);
      send(p, acc);
      wait_out(lat);
      chk("rand_latency", 32'(lat), 32'd44);
      chk("rand_h", 32'(h_out), 32'(eh));
      chk("rand_s", 32'(s_out), 32'(es));
      chk("rand_v", 32'(v_out), 32'(ev));
      take();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
